serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built around the existing one-bit `full_adder` cell. It registers the carry between cycles and processes one bit per clock, LSB first. The block accepts two parallel operands and a carry-in under a start/done handshake, and returns a parallel sum and carry-out after WIDTH cycles. It sits directly downstream of `full_adder`: it instantiates exactly one `full_adder`, feeds its three inputs, and consumes `o_sum`/`o_carry` each cycle.

## Interface

- WIDTH, 8, operand/sum width in bits; legal range 2..32.

- i_clk  input  1  single system clock; all state changes on the rising edge.
- i_rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- i_start  input  1  request pulse; sampled only when the block is ready to accept (see Operation).
- i_a  input  WIDTH  operand A; sampled on the accepting edge only.
- i_b  input  WIDTH  operand B; sampled on the accepting edge only.
- i_cin  input  1  carry-in; sampled on the accepting edge only.
- o_busy  output  1  high while a computation is in progress (RUN state).
- o_done  output  1  one-cycle pulse; marks the cycle in which o_sum/o_cout first hold a new result.
- o_sum  output  WIDTH  registered result; holds the last completed sum.
- o_cout  output  1  registered carry-out of the last completed sum.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - i_start=1 → latch i_a, i_b into right-shift registers, load the carry register with i_cin, clear the bit counter, go to RUN.
- RUN, each cycle:
  - `full_adder` inputs: i_bit1 = A shift reg[0], i_bit2 = B shift reg[0], i_carry = carry reg.
  - On the edge: full_adder o_sum shifts into the MSB of the internal sum shift register (shift right); carry reg ← o_carry; A and B shift right; counter increments.
  - When the counter reaches WIDTH-1, that edge processes the final bit and the state goes to DONE.
  - On the same edge: o_sum ← completed internal sum word (including the final bit); o_cout ← final o_carry.
- DONE, lasts one cycle:
  - o_done=1.
  - i_start=1 here is accepted exactly as in IDLE, for back-to-back operation; otherwise go to IDLE.
- i_start while in RUN: ignored, with no effect on the computation or outputs.
- Arithmetic: {o_cout, o_sum} = i_a + i_b + i_cin, computed modulo 2^(WIDTH+1); no overflow flag.
- Counter width: $clog2(WIDTH) bits; no wrap occurs within one operation.
- o_sum/o_cout change only on a completing edge. They hold through subsequent IDLE and RUN periods.

## Timing

- Reset values:
  - State IDLE.
  - o_busy=0, o_done=0, o_sum=0, o_cout=0.
  - Shift registers, carry reg and counter = 0.
- Latency: i_start accepted at edge E0 → o_busy=1 from E0 to E_WIDTH → o_sum/o_cout valid and o_done=1 for the cycle following edge E_WIDTH.
  - WIDTH=8 example: start at edge 0, done visible after edge 8.
- Throughput: one result per WIDTH+1 cycles with i_start held high continuously.
- o_busy and o_done are never high simultaneously.
- Reset asserted mid-RUN or mid-DONE:
  - The operation is aborted and all outputs clear asynchronously.
  - No o_done is produced for the aborted operation.
  - After reset deassertion the block is in IDLE and accepts i_start on the first edge.
- Operand inputs may change freely after the accepting edge; they do not affect an operation in flight.

## Test plan

- WIDTH=8, i_a=0x5A, i_b=0x3C, i_cin=0, start pulse → o_done exactly 8 edges after the accepting edge; o_sum=0x96, o_cout=0; o_busy high for 8 cycles.
- WIDTH=8, 0xFF + 0x01, cin=0 → o_sum=0x00, o_cout=1. Then 0xFF + 0xFF, cin=1 → o_sum=0xFF, o_cout=1.
- Busy protection: start 0x10+0x20; during cycle 3 pulse i_start with 0xAA+0x55 → o_sum=0x30, single o_done. The second request is not executed.
- Back-to-back: hold i_start=1 with a new operand each acceptance → results arrive every 9 cycles; each result matches its own operands.
- Reset mid-RUN: assert i_rst at cycle 4 of 0x7F+0x01 → o_sum=0, o_cout=0, o_busy=0 immediately; no o_done. A new start 0x03+0x04 afterwards gives o_sum=0x07.
- WIDTH=4 exhaustive: all 512 combinations of {a, b, cin} → {o_cout, o_sum} == a+b+cin; o_done occurs 4 edges after each accepting edge.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder around a single one-bit full_adder cell
//
// full_adder : combinational one-bit full adder.
//   i_bit1, i_bit2, i_carry : addend bits and carry-in
//   o_sum, o_carry          : sum bit and carry-out
//
// serial_adder : adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
//   i_clk   : system clock, rising edge
//   i_rst   : asynchronous active-high reset
//   i_start : request; accepted in IDLE or DONE
//   i_a     : operand A, sampled on the accepting edge
//   i_b     : operand B, sampled on the accepting edge
//   i_cin   : carry-in, sampled on the accepting edge
//   o_busy  : high while in RUN
//   o_done  : one-cycle pulse in the cycle a new result first appears
//   o_sum   : registered sum of the last completed operation
//   o_cout  : registered carry-out of the last completed operation

module full_adder (
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_bit1 ^ i_bit2 ^ i_carry;
  assign o_carry = (i_bit1 & i_bit2) | (i_bit1 & i_carry) | (i_bit2 & i_carry);

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  // Holds the WIDTH-1 bits already produced; the bit coming out of the
  // full_adder this cycle completes the word, so no extra storage bit is needed.
  logic [WIDTH-2:0]   r_sum_sh;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_fa_sum;
  logic               w_fa_carry;
  logic [WIDTH-1:0]   w_sum_word;

  full_adder u_full_adder (
    .i_bit1  (r_a_sh[0]),
    .i_bit2  (r_b_sh[0]),
    .i_carry (r_carry),
    .o_sum   (w_fa_sum),
    .o_carry (w_fa_carry)
  );

  assign w_sum_word = {w_fa_sum, r_sum_sh};

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. DONE accepts a new request exactly like IDLE so that a
  // continuously held i_start yields one result every WIDTH+1 cycles.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_BIT) begin
          w_last       = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: operand shift registers, carry, bit counter and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= i_a;
      r_b_sh   <= i_b;
      r_carry  <= i_cin;
      r_cnt    <= '0;
      r_sum_sh <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_carry  <= w_fa_carry;
      r_sum_sh <= w_sum_word[WIDTH-1:1];
      if (w_last) begin
        // Counter is left at its final value so it never wraps mid-operation.
        r_sum  <= w_sum_word;
        r_cout <= w_fa_carry;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_DONE);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=4)

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a(a8), .i_b(b8), .i_cin(cin8),
    .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_a(a4), .i_b(b4), .i_cin(cin4),
    .o_busy(busy4), .o_done(done4), .o_sum(sum4), .o_cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse a request into dut8, then wait (bounded) for o_done.
  // lat = edges from accepting edge to done; bsy = sampled cycles with o_busy high.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     output int lat, output int bsy, output int both);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
    lat = 0; bsy = 0; both = 0;
    while (!done8 && lat < 20) begin
      if (busy8) bsy++;
      @(posedge clk); #1;
      lat++;
      if (busy8 && done8) both++;
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, output int lat);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bsy, both, ndone;
    logic [7:0] ba [4];
    logic [7:0] bb [4];
    logic       bc [4];
    logic [7:0] es [4];
    logic       ec [4];

    // Reset
    #2 rst = 1'b1;
    #1;
    chk("reset_sum", sum8, 8'h00);
    chk("reset_cout", cout8, 1'b0);
    chk("reset_busy", busy8, 1'b0);
    chk("reset_done", done8, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 0x5A + 0x3C
    op8(8'h5A, 8'h3C, 1'b0, lat, bsy, both);
    chk("t1_latency", lat, 8);
    chk("t1_busy_cycles", bsy, 8);
    chk("t1_busy_done_overlap", both, 0);
    chk("t1_sum", sum8, 8'h96);
    chk("t1_cout", cout8, 1'b0);
    @(posedge clk); #1;
    chk("t1_done_one_cycle", done8, 1'b0);
    chk("t1_sum_hold", sum8, 8'h96);

    // Carry propagation through all bits
    op8(8'hFF, 8'h01, 1'b0, lat, bsy, both);
    chk("t2a_sum", sum8, 8'h00);
    chk("t2a_cout", cout8, 1'b1);
    op8(8'hFF, 8'hFF, 1'b1, lat, bsy, both);
    chk("t2b_sum", sum8, 8'hFF);
    chk("t2b_cout", cout8, 1'b1);
    chk("t2b_latency", lat, 8);

    // Request during RUN is ignored
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        chk("t3_sum_at_done", sum8, 8'h30);
      end
    end
    start8 = 1'b0;
    chk("t3_single_done", ndone, 1);
    chk("t3_sum", sum8, 8'h30);
    chk("t3_cout", cout8, 1'b0);
    chk("t3_idle", busy8, 1'b0);

    // Back-to-back with i_start held high
    ba[0] = 8'h12; bb[0] = 8'h34; bc[0] = 1'b0; es[0] = 8'h46; ec[0] = 1'b0;
    ba[1] = 8'h80; bb[1] = 8'h80; bc[1] = 1'b1; es[1] = 8'h01; ec[1] = 1'b1;
    ba[2] = 8'hC8; bb[2] = 8'h64; bc[2] = 1'b0; es[2] = 8'h2C; ec[2] = 1'b1;
    ba[3] = 8'h01; bb[3] = 8'hFE; bc[3] = 1'b1; es[3] = 8'h00; ec[3] = 1'b1;
    @(negedge clk);
    a8 = ba[0]; b8 = bb[0]; cin8 = bc[0]; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = ba[1]; b8 = bb[1]; cin8 = bc[1];
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      while (!done8 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("t4_latency_%0d", k), lat, 8);
      chk($sformatf("t4_sum_%0d", k), sum8, es[k]);
      chk($sformatf("t4_cout_%0d", k), cout8, ec[k]);
      if (k == 3) begin
        start8 = 1'b0;
      end else begin
        @(posedge clk); #1;
        chk($sformatf("t4_reaccept_busy_%0d", k), busy8, 1'b1);
        if (k + 2 < 4) begin
          a8 = ba[k+2]; b8 = bb[k+2]; cin8 = bc[k+2];
        end
      end
    end
    @(posedge clk); #1;
    chk("t4_back_to_idle", busy8, 1'b0);

    // Reset mid-RUN
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy_before_rst", busy8, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_sum", sum8, 8'h00);
    chk("t5_rst_cout", cout8, 1'b0);
    chk("t5_rst_busy", busy8, 1'b0);
    chk("t5_rst_done", done8, 1'b0);
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    chk("t5_no_done_after_abort", ndone, 0);
    op8(8'h03, 8'h04, 1'b0, lat, bsy, both);
    chk("t5_after_sum", sum8, 8'h07);
    chk("t5_after_latency", lat, 8);

    // WIDTH=4 exhaustive
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] exp5;
          exp5 = 5'(a + b + c);
          op4(4'(a), 4'(b), 1'(c), lat);
          chk($sformatf("w4_%0h_%0h_%0d", a, b, c), {cout4, sum4}, exp5);
          chk($sformatf("w4_lat_%0h_%0h_%0d", a, b, c), lat, 4);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
